vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Single-clock arbiter sharing one 32KB byte-wide synchronous VRAM (spram32k8) between two requesters: video scanout fetch (high priority) and CPU bus (low priority).
- Issues at most one RAM access per cycle and registers all RAM-side signals.
- Tracks in-flight reads so returned data is steered to the originating requester with a valid strobe.
- Sits between the video timing/fetch logic, the CPU bus interface and the VRAM instance.

Parameters:
- AW, 15, VRAM byte address width.
- DW, 8, data width.
- RD_LATENCY, 3, cycles from the ack cycle to the rvalid cycle. This is 1 for the arbiter output register plus 2 for the RAM.
- FAIR_LIMIT, 3, maximum consecutive video grants while the CPU waits. Used only with the optional feature.

Ports:
- clk in 1 system clock, all logic on posedge.
- reset in 1 asynchronous, active-high reset.
- vid_req in 1 video read request; held until vid_ack.
- vid_addr in AW video read address.
- vid_ack out 1 video request accepted this cycle (combinational).
- vid_rvalid out 1 vid_rdata valid this cycle.
- vid_rdata out DW video read data.
- cpu_req in 1 CPU request; held with stable addr/we/wdata until cpu_ack.
- cpu_we in 1 1 = write, 0 = read.
- cpu_addr in AW CPU address.
- cpu_wdata in DW CPU write data.
- cpu_ack out 1 CPU request accepted this cycle (combinational).
- cpu_rvalid out 1 cpu_rdata valid this cycle; never asserted for writes.
- cpu_rdata out DW CPU read data.
- ram_addr out AW to VRAM addr (registered).
- ram_we out 1 to VRAM write_enable (registered).
- ram_wdata out DW to VRAM data_in (registered).
- ram_rdata in DW from VRAM data_out.

Behaviour:
- Reset values:
  - ram_addr = 0, ram_we = 0, ram_wdata = 0.
  - vid_rvalid = 0, cpu_rvalid = 0, vid_ack = 0, cpu_ack = 0.
  - Tag pipeline cleared; fairness counter = 0.
- Reset mid-operation: in-flight reads are discarded, with no rvalid for them after reset deassertion. A request pending at reset is not acked while reset is high.
- Grant each cycle (combinational):
  - If vid_req, grant video.
  - Else if cpu_req, grant CPU.
  - Else idle.
  - ack is high only for the granted requester and only when its req is high.
- At the posedge ending an ack cycle:
  - ram_addr, ram_we and ram_wdata load from the winner. ram_we = cpu_we for the CPU and 0 for video.
  - A tag is pushed: VID, CPU_RD, or NONE for a CPU write.
- Idle cycle: ram_we <= 0, ram_addr/ram_wdata hold, tag NONE pushed.
- Read return:
  - Tags pass through a RD_LATENCY-1 stage delay after the output register.
  - In the cycle exactly RD_LATENCY cycles after the ack cycle, the matching rvalid is high for one cycle.
  - vid_rdata and cpu_rdata both equal ram_rdata and are valid only under their rvalid.
- Throughput: one access per cycle. Back-to-back reads return in issue order with no bubbles.
- Ordering: accesses execute in grant order. A CPU read granted the cycle after a CPU write to the same address returns the new data.
- Writes: the RAM commits one cycle after the ack edge. No write response is given.
- Simultaneous requests: video wins. The CPU stays pending with no ack, and its inputs must remain stable.
- Starvation: without the optional feature, continuous vid_req starves the CPU. This is acceptable because video fetch leaves blanking gaps.
- No combinational path from ram_rdata to any ack.

Optional Feature:
- Macro: VRAM_ARB_FAIR_EN.
- With it defined:
  - A counter increments on each video grant while cpu_req is high.
  - When the counter equals FAIR_LIMIT, the next cycle with cpu_req high grants the CPU even if vid_req is high.
  - The counter clears on any CPU grant, or whenever cpu_req is low.
- Without it: strict video priority, and the counter logic is absent.

Decomposition:
- Package vram_pkg holds:
  - VRAM_AW = 15, VRAM_DW = 8, VRAM_RD_LATENCY = 3.
  - Enum vram_tag_t {TAG_NONE, TAG_VID, TAG_CPU_RD}.
- Sub-module vram_tag_pipe: parameterised-depth shift register of vram_tag_t with asynchronous clear. It outputs the aged tag that drives the rvalids.

Test Plan:
- Single CPU read of 0x1234, preloaded to 0xA5, with vid_req = 0 → cpu_ack in cycle 0, cpu_rvalid only in cycle 3, cpu_rdata = 0xA5.
- CPU writes 0x5A to 0x0001, then reads 0x0001 and 0x0000 back-to-back (0x0000 preloaded to 0x11) → cpu_ack 3 consecutive cycles, rvalids at cycles 4 and 5 with data 0x5A then 0x11.
- vid_req and cpu_req both high at addresses 0x0100 and 0x0200 → vid_ack in cycle 0, cpu_ack in cycle 1, vid_rvalid in cycle 3, cpu_rvalid in cycle 4, each with its own data.
- Continuous video reads over 0x0000–0x000F → 16 consecutive vid_rvalids in address order with no gaps.
- Continuous vid_req plus a waiting cpu_req:
  - With VRAM_ARB_FAIR_EN: cpu_ack exactly after 3 video grants.
  - Without it: no cpu_ack until vid_req drops.
- Reset pulsed 1 cycle after 2 video reads are acked → no vid_rvalid afterwards, ram_we = 0, outputs at reset values.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared widths and read-return tag type for the VRAM arbiter slice.
package vram_pkg;

    localparam int unsigned VRAM_AW         = 15;
    localparam int unsigned VRAM_DW         = 8;
    localparam int unsigned VRAM_RD_LATENCY = 3;

    typedef enum logic [1:0] {
        TAG_NONE   = 2'd0,
        TAG_VID    = 2'd1,
        TAG_CPU_RD = 2'd2
    } vram_tag_t;

    // Tag describing what an access issued this cycle will return.
    function automatic vram_tag_t issue_tag(input logic grant_vid, input logic grant_cpu,
                                            input logic cpu_we);
        vram_tag_t tag;
        tag = TAG_NONE;
        if (grant_vid) begin
            tag = TAG_VID;
        end else if (grant_cpu && !cpu_we) begin
            tag = TAG_CPU_RD;
        end
        return tag;
    endfunction

endpackage

// File: rtl/vram_tag_pipe.sv
// Fixed-depth tag delay line; its last stage lines up with RAM read data.
module vram_tag_pipe
    import vram_pkg::*;
#(
    parameter int unsigned DEPTH = VRAM_RD_LATENCY
) (
    input  logic      clk,
    input  logic      reset,
    input  vram_tag_t tag_in,
    output vram_tag_t tag_out
);

    vram_tag_t stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= TAG_NONE;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Two-port VRAM arbiter: video fetch has priority over CPU, one access per cycle.
// Optional CPU anti-starvation: define VRAM_ARB_FAIR_EN.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned AW         = VRAM_AW,
    parameter int unsigned DW         = VRAM_DW,
`ifdef VRAM_ARB_FAIR_EN
    parameter int unsigned FAIR_LIMIT = 3,
`endif
    parameter int unsigned RD_LATENCY = VRAM_RD_LATENCY
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic          vid_rvalid,
    output logic [DW-1:0] vid_rdata,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    logic      grant_vid;
    logic      grant_cpu;
    logic      fair_force;
    vram_tag_t tag_in;
    vram_tag_t tag_out;

`ifdef VRAM_ARB_FAIR_EN
    localparam int unsigned FCW = $clog2(FAIR_LIMIT + 1);

    logic [FCW-1:0] fair_cnt;

    // Counts video wins over a waiting CPU; never exceeds FAIR_LIMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fair_cnt <= '0;
        end else if (!cpu_req || grant_cpu) begin
            fair_cnt <= '0;
        end else if (grant_vid) begin
            fair_cnt <= fair_cnt + FCW'(1);
        end
    end

    assign fair_force = cpu_req && (fair_cnt == FCW'(FAIR_LIMIT));
`else
    assign fair_force = 1'b0;
`endif

    // Grant decision; nothing is acked while reset is held.
    always_comb begin
        grant_vid = 1'b0;
        grant_cpu = 1'b0;
        if (!reset) begin
            if (fair_force) begin
                grant_cpu = 1'b1;
            end else if (vid_req) begin
                grant_vid = 1'b1;
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end
        end
    end

    assign vid_ack = grant_vid;
    assign cpu_ack = grant_cpu;

    // RAM-side output register; idle cycles only drop the write enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else if (grant_vid) begin
            ram_addr  <= vid_addr;
            ram_we    <= 1'b0;
        end else if (grant_cpu) begin
            ram_addr  <= cpu_addr;
            ram_we    <= cpu_we;
            ram_wdata <= cpu_wdata;
        end else begin
            ram_we    <= 1'b0;
        end
    end

    assign tag_in = issue_tag(grant_vid, grant_cpu, cpu_we);

    // First stage is co-timed with the output register, the rest cover RAM latency.
    vram_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign vid_rvalid = (tag_out == TAG_VID);
    assign cpu_rvalid = (tag_out == TAG_CPU_RD);
    assign vid_rdata  = ram_rdata;
    assign cpu_rdata  = ram_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed table, corner sequences and random traffic
// checked against a transaction-level model with a shadow memory.
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int unsigned AW  = 15;
    localparam int unsigned DW  = 8;
    localparam int          LAT = 3;
`ifdef VRAM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam int FAIR_N = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack, vid_rvalid;
    logic [DW-1:0] vid_rdata;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    vram_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // spram32k8 stand-in: registered address, registered data out.
    logic [DW-1:0] mem [0:32767];
    logic [DW-1:0] rd1 = '0, rd2 = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        rd1 <= mem[ram_addr];
        rd2 <= rd1;
    end
    assign ram_rdata = rd2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input int a);
        logic [14:0] aa;
        aa = 15'(a);
        return aa[7:0] ^ {1'b0, aa[14:8]} ^ 8'h3C;
    endfunction

    // Reference model: grant rule, fairness count, shadow memory, return queue.
    typedef struct { int due; bit vid; logic [7:0] data; } ret_t;
    ret_t          rq[$];
    logic [DW-1:0] shadow [0:32767];
    int            fcnt = 0;

    task automatic model_step();
        bit gv, gc, ev, ec;
        logic [7:0] ed;
        gv = 1'b0; gc = 1'b0; ev = 1'b0; ec = 1'b0; ed = '0;
        if (reset) begin
            rq.delete();
            fcnt = 0;
            chk("rst_vid_ack", 32'(vid_ack), 32'(0));
            chk("rst_cpu_ack", 32'(cpu_ack), 32'(0));
            chk("rst_vid_rvalid", 32'(vid_rvalid), 32'(0));
            chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'(0));
            return;
        end
        if (FAIR && cpu_req && fcnt == FAIR_N) gc = 1'b1;
        else if (vid_req) gv = 1'b1;
        else if (cpu_req) gc = 1'b1;
        chk("m_vid_ack", 32'(vid_ack), 32'(gv));
        chk("m_cpu_ack", 32'(cpu_ack), 32'(gc));
        if (!cpu_req || gc) fcnt = 0;
        else if (gv) fcnt++;
        if (gv) rq.push_back('{cyc + LAT, 1'b1, shadow[vid_addr]});
        else if (gc && !cpu_we) rq.push_back('{cyc + LAT, 1'b0, shadow[cpu_addr]});
        else if (gc) shadow[cpu_addr] = cpu_wdata;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            ev = rq[0].vid;
            ec = !rq[0].vid;
            ed = rq[0].data;
            void'(rq.pop_front());
        end
        chk("m_vid_rvalid", 32'(vid_rvalid), 32'(ev));
        chk("m_cpu_rvalid", 32'(cpu_rvalid), 32'(ec));
        if (ev) chk("m_vid_rdata", 32'(vid_rdata), 32'(ed));
        if (ec) chk("m_cpu_rdata", 32'(cpu_rdata), 32'(ed));
    endtask

    always @(negedge clk) model_step();

    typedef struct {
        bit vr; logic [14:0] va;
        bit cr; bit cw; logic [14:0] ca; logic [7:0] cd;
        bit e_va; bit e_ca; bit e_vv; bit e_cv; logic [7:0] e_d;
    } vec_t;

    task automatic idle_inputs();
        vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    initial begin
        vec_t tbl [18];
        int   rv_k[$];
        logic [7:0] rv_d[$];
        int   first_ack;
        bit   cdone, cp, vp;

        for (int a = 0; a < 32768; a++) begin
            mem[a] = init_val(a);
        end
        mem[15'h1234] = 8'hA5;
        mem[15'h0000] = 8'h11;
        for (int a = 0; a < 32768; a++) shadow[a] = mem[a];

        // Directed vectors: {vr,va,cr,cw,ca,cd, exp vid_ack,cpu_ack,vid_rvalid,cpu_rvalid,data}
        tbl[0]  = '{0, 15'h0000, 1, 0, 15'h1234, 8'h00, 0, 1, 0, 0, 8'h00};
        tbl[1]  = '{0, 15'h0000, 0, 0, 15'h0000, 8'h00, 0, 0, 0, 0, 8'h00};
        tbl[2]  = '{0, 15'h0000, 0, 0, 15'h0000, 8'h00, 0, 0, 0, 0, 8'h00};
        tbl[3]  = '{0, 15'h0000, 0, 0, 15'h0000, 8'h00, 0, 0, 0, 1, 8'hA5};
        tbl[4]  = '{0, 15'h0000, 0, 0, 15'h0000, 8'h00, 0, 0, 0, 0, 8'h00};
        tbl[5]  = '{0, 15'h0000, 1, 1, 15'h0001, 8'h5A, 0, 1, 0, 0, 8'h00};
        tbl[6]  = '{0, 15'h0000, 1, 0, 15'h0001, 8'h00, 0, 1, 0, 0, 8'h00};
        tbl[7]  = '{0, 15'h0000, 1, 0, 15'h0000, 8'h00, 0, 1, 0, 0, 8'h00};
        tbl[8]  = '{0, 15'h0000, 0, 0, 15'h0000, 8'h00, 0, 0, 0, 0, 8'h00};
        tbl[9]  = '{0, 15'h0000, 0, 0, 15'h0000, 8'h00, 0, 0, 0, 1, 8'h5A};
        tbl[10] = '{0, 15'h0000, 0, 0, 15'h0000, 8'h00, 0, 0, 0, 1, 8'h11};
        tbl[11] = '{0, 15'h0000, 0, 0, 15'h0000, 8'h00, 0, 0, 0, 0, 8'h00};
        tbl[12] = '{1, 15'h0100, 1, 0, 15'h0200, 8'h00, 1, 0, 0, 0, 8'h00};
        tbl[13] = '{0, 15'h0000, 1, 0, 15'h0200, 8'h00, 0, 1, 0, 0, 8'h00};
        tbl[14] = '{0, 15'h0000, 0, 0, 15'h0000, 8'h00, 0, 0, 0, 0, 8'h00};
        tbl[15] = '{0, 15'h0000, 0, 0, 15'h0000, 8'h00, 0, 0, 1, 0, 8'h3D};
        tbl[16] = '{0, 15'h0000, 0, 0, 15'h0000, 8'h00, 0, 0, 0, 1, 8'h3E};
        tbl[17] = '{0, 15'h0000, 0, 0, 15'h0000, 8'h00, 0, 0, 0, 0, 8'h00};

        // Reset state
        @(negedge clk);
        chk("rst_ram_addr", 32'(ram_addr), 32'(0));
        chk("rst_ram_we", 32'(ram_we), 32'(0));
        chk("rst_ram_wdata", 32'(ram_wdata), 32'(0));
        @(posedge clk); #1 reset = 1'b0;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            vid_req = tbl[i].vr; vid_addr = tbl[i].va;
            cpu_req = tbl[i].cr; cpu_we = tbl[i].cw;
            cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
            @(negedge clk);
            chk($sformatf("tbl%0d_vid_ack", i), 32'(vid_ack), 32'(tbl[i].e_va));
            chk($sformatf("tbl%0d_cpu_ack", i), 32'(cpu_ack), 32'(tbl[i].e_ca));
            chk($sformatf("tbl%0d_vid_rvalid", i), 32'(vid_rvalid), 32'(tbl[i].e_vv));
            chk($sformatf("tbl%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(tbl[i].e_cv));
            if (tbl[i].e_vv) chk($sformatf("tbl%0d_vid_rdata", i), 32'(vid_rdata), 32'(tbl[i].e_d));
            if (tbl[i].e_cv) chk($sformatf("tbl%0d_cpu_rdata", i), 32'(cpu_rdata), 32'(tbl[i].e_d));
        end

        // Continuous video burst over 0x0000-0x000F
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            idle_inputs();
            vid_req = (k < 16);
            vid_addr = AW'(k);
            @(negedge clk);
            if (vid_rvalid) begin
                rv_k.push_back(k);
                rv_d.push_back(vid_rdata);
            end
        end
        chk("burst_count", 32'(rv_k.size()), 32'(16));
        for (int i = 0; i < 16 && i < rv_k.size(); i++) begin
            chk($sformatf("burst%0d_cycle", i), 32'(rv_k[i]), 32'(i + LAT));
            chk($sformatf("burst%0d_data", i), 32'(rv_d[i]),
                32'((i == 0) ? 8'h11 : (i == 1) ? 8'h5A : init_val(i)));
        end

        // Continuous video with a waiting CPU read
        first_ack = -1;
        cdone = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            vid_req = (k < 8);
            vid_addr = AW'(15'h0040 + k);
            cpu_req = !cdone; cpu_we = 1'b0; cpu_addr = 15'h0010;
            @(negedge clk);
            if (cpu_ack && first_ack < 0) begin
                first_ack = k;
                cdone = 1'b1;
            end
        end
        chk("starve_cpu_ack_cycle", 32'(first_ack), 32'(FAIR ? 3 : 8));
        @(posedge clk); #1 idle_inputs();
        repeat (5) @(posedge clk);

        // Reset pulsed one cycle after two video reads were acked
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            vid_req = 1'b1; vid_addr = AW'(15'h0020 + k);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        vid_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0300; cpu_wdata = 8'hEE;
        @(negedge clk);
        chk("rstmid_cpu_ack", 32'(cpu_ack), 32'(0));
        chk("rstmid_ram_we", 32'(ram_we), 32'(0));
        chk("rstmid_ram_addr", 32'(ram_addr), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rstmid%0d_vid_rvalid", k), 32'(vid_rvalid), 32'(0));
            chk($sformatf("rstmid%0d_ram_we", k), 32'(ram_we), 32'(0));
            @(posedge clk);
        end
        chk("rstmid_no_write", 32'(mem[15'h0300]), 32'(8'h3F));

        // Random traffic against the model
        cp = 1'b0; vp = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            if (!cp && $urandom_range(0, 99) < 60) begin
                cp = 1'b1;
                cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = AW'($urandom_range(0, 31));
                cpu_wdata = DW'($urandom);
            end
            if (!vp && $urandom_range(0, 99) < 45) begin
                vp = 1'b1;
                vid_addr = AW'($urandom_range(0, 31));
            end
            cpu_req = cp;
            vid_req = vp;
            @(negedge clk);
            if (cpu_ack) cp = 1'b0;
            if (vid_ack) vp = 1'b0;
        end
        @(posedge clk); #1 idle_inputs();
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("model_queue_drained", 32'(rq.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
